// File: rtl/dmem_stall_responder_if.sv
// Load/store bus between the MEM stage (master) and the multi-cycle data memory (slave).
// Handshake: the master holds req_i and its payload until rvalid_o; busy_o stalls the pipe.
interface dmem_stall_responder_if;
  logic        req_i;
  logic        we_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic        busy_o;
  logic        rvalid_o;
  logic [31:0] rdata_o;
  logic        err_o;

  modport master (
    output req_i, we_i, addr_i, wdata_i,
    input  busy_o, rvalid_o, rdata_o, err_o
  );

  modport slave (
    input  req_i, we_i, addr_i, wdata_i,
    output busy_o, rvalid_o, rdata_o, err_o
  );
endinterface

// File: rtl/dmem_stall_responder.sv
// Multi-cycle data memory for the MEM stage: accepts one word access, stalls the pipe via
// busy_o for LATENCY+1 cycles, then pulses rvalid_o (with err_o for misaligned/out-of-range).
module dmem_stall_responder #(
  parameter int DEPTH_WORDS = 128,
  parameter int LATENCY     = 3
) (
  input  logic                        clk_i,
  input  logic                        rst_n,
  dmem_stall_responder_if.slave       bus,
  output logic [1:0]                  dbg_state_o
);

  localparam int          IDXW     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [31:0] DEPTH_U  = 32'(DEPTH_WORDS);
  localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic            we_q, we_d;
  logic [31:0]     wdata_q, wdata_d;
  logic            err_q, err_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            mem_we;
  logic            busy;
  logic            fault;

  logic [31:0] mem_q [DEPTH_WORDS];

  // Out-of-range is judged on the full word index, not the truncated one used for storage.
  assign fault = (bus.addr_i[1:0] != 2'b00) || ({2'b00, bus.addr_i[31:2]} >= DEPTH_U);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    mem_we  = 1'b0;
    busy    = 1'b0;
    case (state_q)
      S_IDLE: begin
        busy = bus.req_i;
        if (bus.req_i) begin
          if (fault) begin
            err_d   = 1'b1;
            rdata_d = 32'h0;
            state_d = S_DONE;
          end else begin
            err_d   = 1'b0;
            we_d    = bus.we_i;
            idx_d   = bus.addr_i[IDXW+1:2];
            wdata_d = bus.wdata_i;
            cnt_d   = CNT_INIT;
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        busy = 1'b1;
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = S_DONE;
          if (we_q) mem_we  = 1'b1;
          else      rdata_d = mem_q[idx_q];
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      idx_q   <= '0;
      we_q    <= 1'b0;
      wdata_q <= 32'h0;
      err_q   <= 1'b0;
      rdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  // Storage is deliberately not reset; an access cut short by reset never reaches here.
  always_ff @(posedge clk_i) begin
    if (mem_we) mem_q[idx_q] <= wdata_q;
  end

  // busy is gated by rst_n so a request held during reset does not stall the pipe.
  assign bus.busy_o   = busy & rst_n;
  assign bus.rvalid_o = (state_q == S_DONE);
  assign bus.err_o    = (state_q == S_DONE) & err_q;
  assign bus.rdata_o  = rdata_q;
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_dmem_stall_responder.sv
// Bench for dmem_stall_responder: vector table, hand sequences for reset corners, and a
// randomized transaction run against a word-array model, on LATENCY=3 and LATENCY=1 instances.
module tb_dmem_stall_responder;

  logic clk_i = 1'b0;
  logic rst_n;
  always #5 clk_i = ~clk_i;

  dmem_stall_responder_if if_a ();
  dmem_stall_responder_if if_b ();
  logic [1:0] dbg_a, dbg_b;

  dmem_stall_responder #(.DEPTH_WORDS(128), .LATENCY(3)) u_a (
    .clk_i(clk_i), .rst_n(rst_n), .bus(if_a), .dbg_state_o(dbg_a)
  );
  dmem_stall_responder #(.DEPTH_WORDS(128), .LATENCY(1)) u_b (
    .clk_i(clk_i), .rst_n(rst_n), .bus(if_b), .dbg_state_o(dbg_b)
  );

  typedef struct {
    bit          sel;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        eb;
    logic        ev;
    logic        ee;
    logic [31:0] er;
  } vec_t;

  vec_t        tbl[$];
  logic [31:0] exp_q[$];
  int          checks = 0;
  int          errors = 0;

  logic [31:0] mdl_mem   [2][128];
  bit          mdl_known [2][128];
  logic [31:0] mdl_r     [2];
  bit          mdl_rk    [2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input bit sel, input logic req, input logic we,
                       input logic [31:0] addr, input logic [31:0] wdata);
    if (sel == 1'b0) begin
      if_a.req_i = req; if_a.we_i = we; if_a.addr_i = addr; if_a.wdata_i = wdata;
      if_b.req_i = 1'b0;
    end else begin
      if_b.req_i = req; if_b.we_i = we; if_b.addr_i = addr; if_b.wdata_i = wdata;
      if_a.req_i = 1'b0;
    end
  endtask

  // Entered and left at posedge+1; outputs are sampled on the falling edge.
  task automatic cyc(input bit sel, input logic req, input logic we, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic eb, input logic ev, input logic ee,
                     input logic [31:0] er, input bit cr, input string tag);
    logic        b, v, e;
    logic [31:0] r;
    drive(sel, req, we, addr, wdata);
    @(negedge clk_i);
    if (sel == 1'b0) begin b = if_a.busy_o; v = if_a.rvalid_o; e = if_a.err_o; r = if_a.rdata_o; end
    else             begin b = if_b.busy_o; v = if_b.rvalid_o; e = if_b.err_o; r = if_b.rdata_o; end
    chk({tag, " busy"},   {31'b0, b}, {31'b0, eb});
    chk({tag, " rvalid"}, {31'b0, v}, {31'b0, ev});
    chk({tag, " err"},    {31'b0, e}, {31'b0, ee});
    if (cr) chk({tag, " rdata"}, r, er);
    @(posedge clk_i);
    #1;
  endtask

  // One access as the pipeline sees it: request held through the completion cycle,
  // payload scrambled after the first cycle to prove it was captured.
  task automatic push_acc(input bit sel, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input int nbusy, input logic err,
                          input logic [31:0] prev, input logic [31:0] done_r);
    for (int i = 0; i < nbusy; i++)
      tbl.push_back('{sel, 1'b1, (i == 0) ? we : ~we, (i == 0) ? addr : addr + 32'd4,
                      (i == 0) ? wdata : ~wdata, 1'b1, 1'b0, 1'b0, prev});
    tbl.push_back('{sel, 1'b1, ~we, addr + 32'd4, ~wdata, 1'b0, 1'b1, err, done_r});
  endtask

  task automatic push_idle(input bit sel, input int n, input logic [31:0] prev);
    for (int i = 0; i < n; i++)
      tbl.push_back('{sel, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, prev});
  endtask

  task automatic apply_tbl(input string tag);
    for (int i = 0; i < tbl.size(); i++)
      cyc(tbl[i].sel, tbl[i].req, tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].eb,
          tbl[i].ev, tbl[i].ee, tbl[i].er, 1'b1, $sformatf("%s[%0d]", tag, i));
    tbl.delete();
  endtask

  task automatic rand_txn(input bit sel, input int n);
    int          lat, nb, word, kind, gap;
    logic [31:0] addr, wdata, w, exp_r;
    logic        we;
    bit          flt, known;
    lat   = sel ? 1 : 3;
    kind  = $urandom_range(0, 5);
    word  = $urandom_range(0, 127);
    we    = 1'($urandom_range(0, 1));
    wdata = $urandom;
    if (kind == 0) begin
      addr = (32'(word) << 2) | 32'($urandom_range(1, 3));
    end else if (kind == 1) begin
      w    = $urandom_range(128, 32'h3FFF_FFFF);
      addr = {w[29:0], 2'b00};
    end else begin
      addr = 32'(word) << 2;
    end
    flt = (addr % 4 != 0) || ((addr / 4) >= 128);
    nb  = flt ? 1 : lat + 1;

    if (flt)     begin exp_r = 32'h0;                  known = 1'b1; end
    else if (we) begin exp_r = mdl_r[sel];             known = mdl_rk[sel]; end
    else         begin exp_r = mdl_mem[sel][addr / 4]; known = mdl_known[sel][addr / 4]; end
    if (known) exp_q.push_back(exp_r);

    for (int i = 0; i < nb; i++)
      cyc(sel, 1'b1, (i == 0) ? we : 1'($urandom), (i == 0) ? addr : $urandom,
          (i == 0) ? wdata : $urandom, 1'b1, 1'b0, 1'b0, mdl_r[sel], mdl_rk[sel],
          $sformatf("rnd%0d.busy%0d", n, i));
    cyc(sel, 1'b1, 1'($urandom), $urandom, $urandom, 1'b0, 1'b1, flt,
        known ? exp_q.pop_front() : 32'h0, known, $sformatf("rnd%0d.done", n));

    if (!flt && we) begin
      mdl_mem[sel][addr / 4]   = wdata;
      mdl_known[sel][addr / 4] = 1'b1;
    end
    mdl_r[sel]  = exp_r;
    mdl_rk[sel] = known;

    gap = $urandom_range(0, 2);
    for (int i = 0; i < gap; i++)
      cyc(sel, 1'b0, 1'($urandom), $urandom, $urandom, 1'b0, 1'b0, 1'b0, mdl_r[sel],
          mdl_rk[sel], $sformatf("rnd%0d.gap%0d", n, i));
  endtask

  initial begin
    rst_n = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    #2 rst_n = 1'b0;
    #1;
    chk("rst busy",   {31'b0, if_a.busy_o},   32'h0);
    chk("rst rvalid", {31'b0, if_a.rvalid_o}, 32'h0);
    chk("rst err",    {31'b0, if_a.err_o},    32'h0);
    chk("rst rdata",  if_a.rdata_o,           32'h0);
    chk("rst idle a", {30'b0, dbg_a},         32'h0);
    chk("rst idle b", {30'b0, dbg_b},         32'h0);
    repeat (2) @(posedge clk_i);
    #1 rst_n = 1'b1;
    push_idle(1'b0, 2, 32'h0);
    push_idle(1'b1, 2, 32'h0);
    apply_tbl("post_rst");

    // LATENCY=3: store/load, faults, input hold, req held through completion.
    push_acc(1'b0, 1'b1, 32'h10,  32'hDEAD_BEEF, 4, 1'b0, 32'h0,         32'h0);
    push_acc(1'b0, 1'b0, 32'h10,  32'h0,         4, 1'b0, 32'h0,         32'hDEAD_BEEF);
    push_acc(1'b0, 1'b1, 32'h00,  32'hCAFE_F00D, 4, 1'b0, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    push_acc(1'b0, 1'b0, 32'h202, 32'h0,         1, 1'b1, 32'hDEAD_BEEF, 32'h0);
    push_acc(1'b0, 1'b1, 32'h200, 32'h55AA_55AA, 1, 1'b1, 32'h0,         32'h0);
    push_acc(1'b0, 1'b0, 32'h00,  32'h0,         4, 1'b0, 32'h0,         32'hCAFE_F00D);
    push_acc(1'b0, 1'b1, 32'h24,  32'h1111_1111, 4, 1'b0, 32'hCAFE_F00D, 32'hCAFE_F00D);
    push_acc(1'b0, 1'b1, 32'h20,  32'hA5A5_A5A5, 4, 1'b0, 32'hCAFE_F00D, 32'hCAFE_F00D);
    push_idle(1'b0, 1, 32'hCAFE_F00D);
    push_acc(1'b0, 1'b0, 32'h20,  32'h0,         4, 1'b0, 32'hCAFE_F00D, 32'hA5A5_A5A5);
    push_acc(1'b0, 1'b0, 32'h24,  32'h0,         4, 1'b0, 32'hA5A5_A5A5, 32'h1111_1111);
    // LATENCY=1: two busy cycles, completion on the third.
    push_acc(1'b1, 1'b1, 32'h1FC, 32'h1234_5678, 2, 1'b0, 32'h0,         32'h0);
    push_acc(1'b1, 1'b0, 32'h1FC, 32'h0,         2, 1'b0, 32'h0,         32'h1234_5678);
    apply_tbl("vec");

    // Reset in the second wait cycle of a store: the store must be dropped.
    push_acc(1'b0, 1'b1, 32'h40, 32'h0, 4, 1'b0, 32'h1111_1111, 32'h1111_1111);
    apply_tbl("pre40");
    cyc(1'b0, 1'b1, 1'b1, 32'h40, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 32'h1111_1111, 1'b1, "st40.t0");
    cyc(1'b0, 1'b1, 1'b0, 32'h44, 32'h0,         1'b1, 1'b0, 1'b0, 32'h1111_1111, 1'b1, "st40.t1");
    drive(1'b0, 1'b1, 1'b0, 32'h48, 32'h0);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst busy",   {31'b0, if_a.busy_o},   32'h0);
    chk("midrst rvalid", {31'b0, if_a.rvalid_o}, 32'h0);
    chk("midrst err",    {31'b0, if_a.err_o},    32'h0);
    chk("midrst rdata",  if_a.rdata_o,           32'h0);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(posedge clk_i);
    #1 rst_n = 1'b1;
    push_idle(1'b0, 3, 32'h0);
    push_acc(1'b0, 1'b0, 32'h40, 32'h0, 4, 1'b0, 32'h0, 32'h0);
    apply_tbl("post40");

    // Randomized traffic on both instances against the word-array model.
    for (int s = 0; s < 2; s++) begin
      mdl_r[s]  = 32'h0;
      mdl_rk[s] = 1'b1;
      for (int i = 0; i < 128; i++) begin
        mdl_mem[s][i]   = 32'h0;
        mdl_known[s][i] = 1'b0;
      end
    end
    for (int n = 0; n < 120; n++) rand_txn(1'($urandom_range(0, 1)), n);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
